sirv_tlresponder_qspi_1: RTL and testbench
==========================================

Name: sirv_tlresponder_qspi_1

Overview:
- TileLink-UL responder (slave end) for the 8-bit QSPI fragmented bus.
- Accepts the single-byte A-channel requests produced by the QSPI fragmenter: 7-bit source, containing the fragment number.
- Performs each access on a simple byte-wide memory/register back-end port.
- Returns exactly one D-channel response per request, with source echoed unchanged so the fragmenter can reassemble.

Parameters:
- TIMEOUT, 255, max cycles in WAIT before a timeout error response (1..255; 8-bit counter).

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous active-high reset
- io_in_0_a_ready  out  1  A accept
- io_in_0_a_valid  in  1  A request valid
- io_in_0_a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
- io_in_0_a_bits_param  in  3  ignored
- io_in_0_a_bits_size  in  3  log2 bytes; only 0 supported
- io_in_0_a_bits_source  in  7  request ID
- io_in_0_a_bits_address  in  30  byte address
- io_in_0_a_bits_mask  in  1  byte lane enable
- io_in_0_a_bits_data  in  8  write data
- io_in_0_d_ready  in  1  D accept
- io_in_0_d_valid  out  1  response valid
- io_in_0_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData
- io_in_0_d_bits_param  out  2  constant 0
- io_in_0_d_bits_size  out  3  echoed size
- io_in_0_d_bits_source  out  7  echoed source
- io_in_0_d_bits_sink  out  1  constant 0
- io_in_0_d_bits_addr_lo  out  1  latched address[0]
- io_in_0_d_bits_data  out  8  read data (0 for acks)
- io_in_0_d_bits_error  out  1  error flag
- io_mem_req_valid  out  1  back-end request
- io_mem_req_ready  in  1  back-end accept
- io_mem_req_write  out  1  1=write
- io_mem_req_addr  out  30  address
- io_mem_req_wdata  out  8  write data
- io_mem_rsp_valid  in  1  back-end completion (single-cycle pulse)
- io_mem_rsp_rdata  in  8  read data
- io_mem_rsp_error  in  1  back-end error

Behaviour:
- Reset (async, any state): state=IDLE; all regs 0; a_ready=1; d_valid=0; mem_req_valid=0; all d_bits 0.
- Transitions are taken at the clock edge when the fire condition holds; there are no combinational paths from A inputs to D or mem outputs.

FSM state IDLE:
- a_ready=1.
- On a_valid, latch opcode, size, source, address, mask, data.
- If the request is illegal (opcode not in {0,1,4}, or size!=0): set err=1, rdata=0, go to RESP. No back-end access.
- Else if opcode=1 and mask=0: no write, err=0, go to RESP.
- Else go to REQ.

FSM state REQ:
- mem_req_valid=1; write = (opcode!=4); addr and wdata come from the latches.
- Outputs are held stable until req_ready.
- On req_ready, go to WAIT; the timeout counter clears to 0.

FSM state WAIT:
- The counter increments each cycle.
- If rsp_valid: capture rdata (only for Get, else 0) and err=rsp_error, then go to RESP.
- Else if counter==TIMEOUT-1: err=1, rdata=0, go to RESP.
- rsp_valid and the timeout condition in the same cycle: the response wins.
- rsp_valid outside WAIT is ignored; this includes a late response after a timeout.

FSM state RESP:
- d_valid=1.
- d opcode = 1 if latched opcode=4 else 0; this also applies to illegal Gets.
- d size and source are echoed; addr_lo = address[0]; data = rdata; error = err.
- All d outputs are held stable while d_ready=0.
- On d_ready, go to IDLE.

Ordering:
- One transaction outstanding.
- a_ready is low in REQ, WAIT and RESP.
- Back-to-back throughput with zero-latency back-end and d_ready=1: one request per 4 cycles (IDLE→REQ→WAIT→RESP).

Test Plan:
- Get addr=0x0000_0010, source=0x25; back-end returns 0xA5 two cycles after req_ready → one d beat: opcode=1, source=0x25, data=0xA5, error=0, addr_lo=0.
- PutFull addr=0x3, data=0x5A, mask=1 → mem write addr=0x3, wdata=0x5A, write=1; d opcode=0, data=0, addr_lo=1, error=0.
- PutPartial mask=0 → no mem_req_valid pulse; d AccessAck, error=0. Get with size=2 → no mem access; d opcode=1, error=1, size=2.
- Back-end never responds, TIMEOUT=4 → d_valid rises 4 cycles after entering WAIT with error=1. A rsp_valid pulse arriving afterwards produces no extra d beat.
- Backpressure: d_ready held 0 for 5 cycles → d bits stable, a_ready=0 throughout. Then d_ready=1 → a_ready=1 the next cycle.
- Assert reset while in WAIT → d_valid=0, mem_req_valid=0, a_ready=1 immediately. A new Get after reset completes normally.

Source files
------------

// File: rtl/sirv_tlresponder_qspi_1_if.sv
// TileLink-UL A/D channel plus byte-wide back-end port for the QSPI responder.
// The slave modport is the responder's view; master is the requester/back-end side.
interface sirv_tlresponder_qspi_1_if;
    logic        io_in_0_a_ready;
    logic        io_in_0_a_valid;
    logic [2:0]  io_in_0_a_bits_opcode;
    logic [2:0]  io_in_0_a_bits_param;
    logic [2:0]  io_in_0_a_bits_size;
    logic [6:0]  io_in_0_a_bits_source;
    logic [29:0] io_in_0_a_bits_address;
    logic        io_in_0_a_bits_mask;
    logic [7:0]  io_in_0_a_bits_data;
    logic        io_in_0_d_ready;
    logic        io_in_0_d_valid;
    logic [2:0]  io_in_0_d_bits_opcode;
    logic [1:0]  io_in_0_d_bits_param;
    logic [2:0]  io_in_0_d_bits_size;
    logic [6:0]  io_in_0_d_bits_source;
    logic        io_in_0_d_bits_sink;
    logic        io_in_0_d_bits_addr_lo;
    logic [7:0]  io_in_0_d_bits_data;
    logic        io_in_0_d_bits_error;
    logic        io_mem_req_valid;
    logic        io_mem_req_ready;
    logic        io_mem_req_write;
    logic [29:0] io_mem_req_addr;
    logic [7:0]  io_mem_req_wdata;
    logic        io_mem_rsp_valid;
    logic [7:0]  io_mem_rsp_rdata;
    logic        io_mem_rsp_error;

    modport slave (
        output io_in_0_a_ready,
        input  io_in_0_a_valid, io_in_0_a_bits_opcode, io_in_0_a_bits_param,
        input  io_in_0_a_bits_size, io_in_0_a_bits_source, io_in_0_a_bits_address,
        input  io_in_0_a_bits_mask, io_in_0_a_bits_data,
        input  io_in_0_d_ready,
        output io_in_0_d_valid, io_in_0_d_bits_opcode, io_in_0_d_bits_param,
        output io_in_0_d_bits_size, io_in_0_d_bits_source, io_in_0_d_bits_sink,
        output io_in_0_d_bits_addr_lo, io_in_0_d_bits_data, io_in_0_d_bits_error,
        output io_mem_req_valid, io_mem_req_write, io_mem_req_addr, io_mem_req_wdata,
        input  io_mem_req_ready,
        input  io_mem_rsp_valid, io_mem_rsp_rdata, io_mem_rsp_error
    );

    modport master (
        input  io_in_0_a_ready,
        output io_in_0_a_valid, io_in_0_a_bits_opcode, io_in_0_a_bits_param,
        output io_in_0_a_bits_size, io_in_0_a_bits_source, io_in_0_a_bits_address,
        output io_in_0_a_bits_mask, io_in_0_a_bits_data,
        output io_in_0_d_ready,
        input  io_in_0_d_valid, io_in_0_d_bits_opcode, io_in_0_d_bits_param,
        input  io_in_0_d_bits_size, io_in_0_d_bits_source, io_in_0_d_bits_sink,
        input  io_in_0_d_bits_addr_lo, io_in_0_d_bits_data, io_in_0_d_bits_error,
        input  io_mem_req_valid, io_mem_req_write, io_mem_req_addr, io_mem_req_wdata,
        output io_mem_req_ready,
        output io_mem_rsp_valid, io_mem_rsp_rdata, io_mem_rsp_error
    );
endinterface

// File: rtl/sirv_tlresponder_qspi_1.sv
// Single-outstanding TileLink-UL responder for byte-sized QSPI fragments.
// Each A request becomes at most one back-end access and exactly one D beat.
module sirv_tlresponder_qspi_1 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    sirv_tlresponder_qspi_1_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [2:0]  opcode_q, size_q;
    logic [6:0]  source_q;
    logic [29:0] address_q;
    logic [7:0]  wdata_q, rdata_q, cnt_q;
    logic        err_q;
    logic        illegal, no_write, timeout_hit;

    assign illegal = !(bus.io_in_0_a_bits_opcode == 3'd0 || bus.io_in_0_a_bits_opcode == 3'd1 ||
                       bus.io_in_0_a_bits_opcode == 3'd4) || (bus.io_in_0_a_bits_size != 3'd0);
    assign no_write    = (bus.io_in_0_a_bits_opcode == 3'd1) && !bus.io_in_0_a_bits_mask;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.io_in_0_a_valid) state_nxt = (illegal || no_write) ? RESP : REQ;
            REQ:  if (bus.io_mem_req_ready) state_nxt = WAIT;
            WAIT: if (bus.io_mem_rsp_valid || timeout_hit) state_nxt = RESP;
            RESP: if (bus.io_in_0_d_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcode_q  <= '0;
            size_q    <= '0;
            source_q  <= '0;
            address_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.io_in_0_a_valid) begin
                    opcode_q  <= bus.io_in_0_a_bits_opcode;
                    size_q    <= bus.io_in_0_a_bits_size;
                    source_q  <= bus.io_in_0_a_bits_source;
                    address_q <= bus.io_in_0_a_bits_address;
                    wdata_q   <= bus.io_in_0_a_bits_data;
                    rdata_q   <= '0;
                    err_q     <= illegal;
                end
                REQ: if (bus.io_mem_req_ready) cnt_q <= '0;
                WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A response landing on the last timeout cycle still wins.
                    if (bus.io_mem_rsp_valid) begin
                        rdata_q <= (opcode_q == 3'd4) ? bus.io_mem_rsp_rdata : 8'd0;
                        err_q   <= bus.io_mem_rsp_error;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.io_in_0_a_ready        = (state == IDLE);
    assign bus.io_in_0_d_valid        = (state == RESP);
    assign bus.io_in_0_d_bits_opcode  = (opcode_q == 3'd4) ? 3'd1 : 3'd0;
    assign bus.io_in_0_d_bits_param   = 2'd0;
    assign bus.io_in_0_d_bits_size    = size_q;
    assign bus.io_in_0_d_bits_source  = source_q;
    assign bus.io_in_0_d_bits_sink    = 1'b0;
    assign bus.io_in_0_d_bits_addr_lo = address_q[0];
    assign bus.io_in_0_d_bits_data    = rdata_q;
    assign bus.io_in_0_d_bits_error   = err_q;

    assign bus.io_mem_req_valid = (state == REQ);
    assign bus.io_mem_req_write = (opcode_q != 3'd4);
    assign bus.io_mem_req_addr  = address_q;
    assign bus.io_mem_req_wdata = wdata_q;
endmodule

// File: tb/tb_sirv_tlresponder_qspi_1.sv
// Randomized scoreboard bench: requester, back-end device and D-channel monitor run as
// independent processes; expected beats come from a memory-level reference model.
module tb_sirv_tlresponder_qspi_1;
    localparam int TO = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sirv_tlresponder_qspi_1_if bus();
    sirv_tlresponder_qspi_1 #(.TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic [2:0] op; logic [2:0] size; logic [6:0] src;
        logic addr_lo; logic [7:0] data; logic err;
    } dexp_t;
    typedef struct {
        logic write; logic [29:0] addr; logic [7:0] wdata;
        int stall; int lat; logic err; logic [7:0] junk; bit drop; bit tchk;
    } plan_t;

    dexp_t sb[$];
    plan_t mq[$];
    logic [7:0] ref_mem [logic [29:0]];
    logic [7:0] bmem    [logic [29:0]];
    int checks = 0, passes = 0;
    int dr_mode = 0;  // 0 random d_ready, 1 held low, 2 held high

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [22:0] dpack(input dexp_t e);
        return {e.op, e.size, e.src, e.addr_lo, e.data, e.err};
    endfunction

    function automatic logic [22:0] dact();
        return {bus.io_in_0_d_bits_opcode, bus.io_in_0_d_bits_size, bus.io_in_0_d_bits_source,
                bus.io_in_0_d_bits_addr_lo, bus.io_in_0_d_bits_data, bus.io_in_0_d_bits_error};
    endfunction

    task automatic preload(input logic [29:0] a, input logic [7:0] v);
        ref_mem[a] = v;
        bmem[a]    = v;
    endtask

    // Reference model: decide the outcome of a request from the protocol rules alone.
    task automatic issue(input logic [2:0] op, input logic [2:0] size, input logic [6:0] src,
                         input logic [29:0] addr, input logic mask, input logic [7:0] data,
                         input int stall, input int lat, input bit err, input bit drop, input bit tchk);
        dexp_t e; plan_t p; bit legal; int n;
        legal = (op == 3'd0 || op == 3'd1 || op == 3'd4) && size == 3'd0;
        e.op = (op == 3'd4) ? 3'd1 : 3'd0;
        e.size = size; e.src = src; e.addr_lo = addr[0]; e.data = 8'd0; e.err = 1'b0;
        if (!legal) e.err = 1'b1;
        else if (!(op == 3'd1 && !mask)) begin
            p.write = (op != 3'd4); p.addr = addr; p.wdata = data;
            p.stall = stall; p.lat = lat; p.err = err; p.junk = 8'($urandom);
            p.drop = drop; p.tchk = tchk;
            if (drop) e.err = 1'b1;
            else begin
                e.err = err;
                if (op == 3'd4) e.data = err ? p.junk : (ref_mem.exists(addr) ? ref_mem[addr] : 8'd0);
                else if (!err) ref_mem[addr] = data;
            end
            mq.push_back(p);
        end
        sb.push_back(e);
        @(posedge clock); #1;
        bus.io_in_0_a_valid = 1'b1;
        bus.io_in_0_a_bits_opcode = op;   bus.io_in_0_a_bits_param = 3'($urandom);
        bus.io_in_0_a_bits_size = size;   bus.io_in_0_a_bits_source = src;
        bus.io_in_0_a_bits_address = addr; bus.io_in_0_a_bits_mask = mask;
        bus.io_in_0_a_bits_data = data;
        n = 0;
        @(negedge clock);
        while (!bus.io_in_0_a_ready && n < 500) begin @(negedge clock); n++; end
        if (n >= 500) begin
            $display("FAIL a_accept: a_ready stayed 0 for %0d cycles, required 1", n);
            $fatal(1);
        end
        @(posedge clock); #1;
        bus.io_in_0_a_valid = 1'b0;
        bus.io_in_0_a_bits_opcode = 3'($urandom); bus.io_in_0_a_bits_address = 30'($urandom);
        bus.io_in_0_a_bits_data = 8'($urandom);   bus.io_in_0_a_bits_mask = 1'($urandom);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((sb.size() != 0 || mq.size() != 0) && n < maxc) begin @(negedge clock); n++; end
        if (n >= maxc) begin
            checks++;
            $display("FAIL drain: %0d beats and %0d mem accesses pending, required 0", sb.size(), mq.size());
        end
    endtask

    // d_ready driver
    initial begin
        bus.io_in_0_d_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            case (dr_mode)
                0:       bus.io_in_0_d_ready = ($urandom_range(0, 3) != 0);
                1:       bus.io_in_0_d_ready = 1'b0;
                default: bus.io_in_0_d_ready = 1'b1;
            endcase
        end
    end

    // Back-end device: checks each access against the plan, then responds as planned.
    initial begin
        plan_t p; logic [4:0] seen;
        bus.io_mem_req_ready = 1'b0; bus.io_mem_rsp_valid = 1'b0;
        bus.io_mem_rsp_rdata = 8'd0; bus.io_mem_rsp_error = 1'b0;
        forever begin
            @(negedge clock);
            if (reset || !bus.io_mem_req_valid) continue;
            if (mq.size() == 0) begin
                checks++;
                $display("FAIL mem_unexpected: access addr %0h write %0b with none required",
                         bus.io_mem_req_addr, bus.io_mem_req_write);
                p.write = 1'b0; p.addr = '0; p.wdata = '0; p.stall = 0; p.lat = 0;
                p.err = 1'b0; p.junk = '0; p.drop = 1'b0; p.tchk = 1'b0;
            end else begin
                p = mq.pop_front();
                chk("mem_req", 64'({bus.io_mem_req_write, bus.io_mem_req_addr,
                                    bus.io_mem_req_write ? bus.io_mem_req_wdata : 8'd0}),
                               64'({p.write, p.addr, p.write ? p.wdata : 8'd0}));
            end
            repeat (p.stall) begin @(posedge clock); #1; end
            bus.io_mem_req_ready = 1'b1;
            @(posedge clock); #1;
            bus.io_mem_req_ready = 1'b0;
            if (p.drop) begin
                seen = '0;
                for (int k = 0; k < 5; k++) begin @(negedge clock); seen[k] = bus.io_in_0_d_valid; end
                if (p.tchk) chk("timeout_latency", 64'(seen), 64'(5'b10000));
                @(posedge clock); #1;
                bus.io_mem_rsp_valid = 1'b1; bus.io_mem_rsp_rdata = 8'($urandom); bus.io_mem_rsp_error = 1'b0;
                @(posedge clock); #1;
                bus.io_mem_rsp_valid = 1'b0;
            end else begin
                repeat (p.lat) begin @(posedge clock); #1; end
                bus.io_mem_rsp_valid = 1'b1;
                bus.io_mem_rsp_error = p.err;
                if (p.err) bus.io_mem_rsp_rdata = p.junk;
                else if (p.write) bus.io_mem_rsp_rdata = 8'($urandom);
                else bus.io_mem_rsp_rdata = bmem.exists(p.addr) ? bmem[p.addr] : 8'd0;
                if (p.write && !p.err) bmem[p.addr] = p.wdata;
                @(posedge clock); #1;
                bus.io_mem_rsp_valid = 1'b0;
            end
        end
    end

    // D-channel monitor
    bit mon_held = 0, mon_post = 0;
    logic [22:0] mon_bits;
    initial begin
        dexp_t e; logic [22:0] act;
        forever begin
            @(negedge clock);
            if (reset) begin mon_held = 0; mon_post = 0; continue; end
            act = dact();
            if (mon_post) begin
                chk("a_ready_after_d", 64'(bus.io_in_0_a_ready), 64'(1));
                mon_post = 0;
            end
            if (mon_held)
                chk("d_stall_stable", 64'({bus.io_in_0_d_valid, bus.io_in_0_a_ready, act}),
                                      64'({1'b1, 1'b0, mon_bits}));
            mon_held = 0;
            if (bus.io_in_0_d_valid) begin
                if (bus.io_in_0_d_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        $display("FAIL d_unexpected: beat %0h with no request outstanding", act);
                    end else begin
                        e = sb.pop_front();
                        chk("d_beat", 64'(act), 64'(dpack(e)));
                    end
                    mon_post = 1;
                end else begin
                    mon_held = 1;
                    mon_bits = act;
                end
            end
        end
    end

    initial begin
        logic [2:0] ill [5];
        logic [2:0] op, size; logic [29:0] addr; int r, n;
        ill[0] = 3'd2; ill[1] = 3'd3; ill[2] = 3'd5; ill[3] = 3'd6; ill[4] = 3'd7;
        bus.io_in_0_a_valid = 1'b0; bus.io_in_0_a_bits_opcode = '0; bus.io_in_0_a_bits_param = '0;
        bus.io_in_0_a_bits_size = '0; bus.io_in_0_a_bits_source = '0; bus.io_in_0_a_bits_address = '0;
        bus.io_in_0_a_bits_mask = '0; bus.io_in_0_a_bits_data = '0;
        repeat (2) @(negedge clock);
        chk("reset_state", 64'({bus.io_in_0_a_ready, bus.io_in_0_d_valid, bus.io_mem_req_valid, dact(),
                                bus.io_in_0_d_bits_param, bus.io_in_0_d_bits_sink}), 64'({1'b1, 28'd0}));
        reset = 1'b0;

        preload(30'h10, 8'hA5);
        issue(3'd4, 3'd0, 7'h25, 30'h10, 1'b1, 8'h00, 0, 2, 0, 0, 1);     // Get returns 0xA5
        issue(3'd0, 3'd0, 7'h11, 30'h3,  1'b1, 8'h5A, 1, 0, 0, 0, 1);     // PutFull
        issue(3'd1, 3'd0, 7'h12, 30'h7,  1'b0, 8'h33, 0, 0, 0, 0, 1);     // masked PutPartial
        issue(3'd4, 3'd2, 7'h13, 30'h8,  1'b1, 8'h00, 0, 0, 0, 0, 1);     // Get size=2
        issue(3'd4, 3'd0, 7'h14, 30'h3,  1'b1, 8'h00, 0, 0, 0, 1, 1);     // back-end silent
        issue(3'd4, 3'd0, 7'h15, 30'h3,  1'b1, 8'h00, 0, TO-1, 0, 0, 1);  // response on last cycle
        issue(3'd1, 3'd0, 7'h16, 30'h9,  1'b1, 8'hC3, 2, 1, 0, 0, 1);     // PutPartial mask=1
        issue(3'd4, 3'd0, 7'h17, 30'h9,  1'b1, 8'h00, 0, 0, 0, 0, 1);
        drain(300);

        // Backpressure
        @(negedge clock); dr_mode = 1;
        issue(3'd4, 3'd0, 7'h2A, 30'h10, 1'b1, 8'h00, 0, 0, 0, 0, 1);
        n = 0;
        while (!bus.io_in_0_d_valid && n < 50) begin @(negedge clock); n++; end
        chk("bp_d_valid", 64'(bus.io_in_0_d_valid), 64'(1));
        repeat (5) @(negedge clock);
        dr_mode = 2;
        drain(100);
        @(negedge clock); dr_mode = 0;

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) op = 3'd4; else if (r < 5) op = 3'd0; else if (r < 8) op = 3'd1;
            else op = ill[$urandom_range(0, 4)];
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            addr = 30'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) addr[29] = 1'b1;
            issue(op, size, 7'($urandom), addr, 1'($urandom), 8'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, TO - 1),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 1);
        end
        drain(3000);

        // Reset while waiting on the back-end
        issue(3'd4, 3'd0, 7'h3C, 30'h4, 1'b1, 8'h00, 0, 0, 0, 1, 0);
        n = 0;
        while (!bus.io_mem_req_valid && n < 50) begin @(negedge clock); n++; end
        while (bus.io_mem_req_valid && n < 100) begin @(negedge clock); n++; end
        #1 reset = 1'b1;
        #1 chk("reset_in_wait", 64'({bus.io_in_0_d_valid, bus.io_mem_req_valid, bus.io_in_0_a_ready}),
                                64'(3'b001));
        sb.delete();
        @(negedge clock); reset = 1'b0;
        preload(30'h21, 8'h6E);
        issue(3'd4, 3'd0, 7'h3D, 30'h21, 1'b1, 8'h00, 0, 1, 0, 0, 1);
        drain(300);
        repeat (10) @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
